// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and pointer helpers for the async FIFO control blocks
//   DEF_PTR_WIDTH   : default pointer width, including the wrap bit
//   DEF_SYNC_STAGES : default synchroniser depth
//   DEPTH           : FIFO depth for the default pointer width
//   depth_of()      : FIFO depth for a given pointer width
//   gray2bin()      : Gray to binary conversion, zero-extended to 32 bits
package fifo_pkg;

    localparam int DEF_PTR_WIDTH   = 12;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic int depth_of(input int w);
        return 1 << (w - 1);
    endfunction

    localparam int DEPTH = depth_of(DEF_PTR_WIDTH);

    // Zero-extending a Gray value keeps the upper binary bits at zero,
    // so one fixed-width converter serves every pointer width up to 32.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// gray_sync: multi-flop synchroniser for a Gray-coded pointer bus
//   Clk      : destination-domain clock
//   Clear_in : synchronous active-high clear, empties every stage
//   d        : Gray bus from the foreign clock domain
//   q        : synchronised Gray bus, SYNC_STAGES cycles later
module gray_sync #(
    parameter int PTR_WIDTH   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clk,
    input  logic                 Clear_in,
    input  logic [PTR_WIDTH-1:0] d,
    output logic [PTR_WIDTH-1:0] q
);

    // Pure flop chain: only one Gray bit changes per pointer step, so a
    // metastable capture resolves to either the old or the new pointer.
    logic [PTR_WIDTH-1:0] stg [SYNC_STAGES];

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i - 1];
        end
    end

    assign q = stg[SYNC_STAGES - 1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain control for the async FIFO (empty, level and error flags)
//   Clk             : read-domain clock
//   Clear_in        : synchronous active-high clear, highest priority
//   WrGray_in       : Gray write pointer, asynchronous to Clk
//   RdGray_in       : Gray read pointer from the local read counter
//   RdReq_in        : consumer read request
//   RdEn_out        : read enable to the read counter and RAM read port
//   Empty_out       : FIFO empty, exact, from registers only
//   AlmostEmpty_out : Level_out <= ALMOST_EMPTY_TH, or empty
//   Level_out       : registered fill level, lags Empty_out
//   Underflow_out   : sticky, read requested while empty
//   LevelErr_out    : sticky, computed level exceeded DEPTH
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH       = DEF_PTR_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int ALMOST_EMPTY_TH = 4
) (
    input  logic                 Clk,
    input  logic                 Clear_in,
    input  logic [PTR_WIDTH-1:0] WrGray_in,
    input  logic [PTR_WIDTH-1:0] RdGray_in,
    input  logic                 RdReq_in,
    output logic                 RdEn_out,
    output logic                 Empty_out,
    output logic                 AlmostEmpty_out,
    output logic [PTR_WIDTH-1:0] Level_out,
    output logic                 Underflow_out,
    output logic                 LevelErr_out
);

    localparam logic [PTR_WIDTH-1:0] DEPTH_L = PTR_WIDTH'(depth_of(PTR_WIDTH));
    localparam logic [PTR_WIDTH-1:0] AE_TH   = PTR_WIDTH'(ALMOST_EMPTY_TH);

    logic [PTR_WIDTH-1:0] wr_sync;
    logic [PTR_WIDTH-1:0] wr_bin_r;
    logic [PTR_WIDTH-1:0] rd_bin;
    logic [PTR_WIDTH-1:0] level_next;

    gray_sync #(
        .PTR_WIDTH  (PTR_WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_wr_sync (
        .Clk     (Clk),
        .Clear_in(Clear_in),
        .d       (WrGray_in),
        .q       (wr_sync)
    );

    // Comparing Gray codes directly keeps Empty_out off the converter path.
    assign Empty_out       = (wr_sync == RdGray_in);
    assign RdEn_out        = RdReq_in & ~Empty_out;
    assign AlmostEmpty_out = (Level_out <= AE_TH) | Empty_out;
    assign rd_bin          = PTR_WIDTH'(gray2bin(32'(RdGray_in)));
    // Modulo subtraction handles the pointer wrap without a special case.
    assign level_next      = wr_bin_r - rd_bin;

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            wr_bin_r      <= '0;
            Level_out     <= '0;
            Underflow_out <= 1'b0;
            LevelErr_out  <= 1'b0;
        end else begin
            wr_bin_r      <= PTR_WIDTH'(gray2bin(32'(wr_sync)));
            Level_out     <= level_next;
            Underflow_out <= Underflow_out | (RdReq_in & Empty_out);
            LevelErr_out  <= LevelErr_out | (level_next > DEPTH_L);
        end
    end

endmodule
